// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial adder controller driving one external full_adder cell.
// Operands are latched on an accepted start, fed LSB first through fa_a/fa_b/fa_cin,
// and the returned sum bits are shifted into a WIDTH-bit result with a one-cycle done.
// Optional feature macro: SERIAL_ADDER_OVF_EN adds a signed-overflow output.
module serial_adder_ctrl #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             fa_a,
   output logic             fa_b,
   output logic             fa_cin,
   input  logic             fa_sum,
   input  logic             fa_cout,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
   output logic             overflow,
`endif
   output logic             cout
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             run;
   logic             last_step;
`ifdef SERIAL_ADDER_OVF_EN
   logic             ovf_q, ovf_d;
`endif

   assign run       = (state_q == S_RUN);
   assign last_step = run && (cnt_q == LAST_BIT);

   // Cell-facing bits and status, all decoded from registers.
   always_comb begin
      fa_a   = run ? a_sh_q[0] : 1'b0;
      fa_b   = run ? b_sh_q[0] : 1'b0;
      fa_cin = run ? carry_q   : 1'b0;
      busy   = run;
      done   = (state_q == S_DONE);
      sum    = sum_q;
      cout   = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
      overflow = ovf_q;
`endif
   end

   // FSM sequencing and datapath next-state.
   always_comb begin
      state_d  = state_q;
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      sum_sh_d = sum_sh_q;
      sum_d    = sum_q;
      carry_d  = carry_q;
      cout_d   = cout_q;
      cnt_d    = cnt_q;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_d    = ovf_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               a_sh_d  = a;
               b_sh_d  = b;
               carry_d = cin;
               cnt_d   = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            a_sh_d   = a_sh_q >> 1;
            b_sh_d   = b_sh_q >> 1;
            sum_sh_d = {fa_sum, sum_sh_q[WIDTH-1:1]};
            carry_d  = fa_cout;
            if (last_step) begin
               // Result is taken from the shifted value including this edge's bit.
               sum_d   = {fa_sum, sum_sh_q[WIDTH-1:1]};
               cout_d  = fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
               ovf_d   = fa_cin ^ fa_cout;
`endif
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         sum_sh_q <= '0;
         sum_q    <= '0;
         carry_q  <= 1'b0;
         cout_q   <= 1'b0;
         cnt_q    <= '0;
`ifdef SERIAL_ADDER_OVF_EN
         ovf_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         a_sh_q   <= a_sh_d;
         b_sh_q   <= b_sh_d;
         sum_sh_q <= sum_sh_d;
         sum_q    <= sum_d;
         carry_q  <= carry_d;
         cout_q   <= cout_d;
         cnt_q    <= cnt_d;
`ifdef SERIAL_ADDER_OVF_EN
         ovf_q    <= ovf_d;
`endif
      end
   end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl; the full_adder cell is modelled in the bench.
module tb_serial_adder_ctrl;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   // WIDTH=8 instance
   logic       start8, cin8;
   logic [7:0] a8, b8, sum8;
   logic       fa_a8, fa_b8, fa_cin8, fa_sum8, fa_cout8, busy8, done8, cout8;
   logic       ovf8;

   // WIDTH=4 instance
   logic       start4, cin4;
   logic [3:0] a4, b4, sum4;
   logic       fa_a4, fa_b4, fa_cin4, fa_sum4, fa_cout4, busy4, done4, cout4;
   logic       ovf4;

   assign fa_sum8  = fa_a8 ^ fa_b8 ^ fa_cin8;
   assign fa_cout8 = (fa_a8 & fa_b8) | (fa_a8 & fa_cin8) | (fa_b8 & fa_cin8);
   assign fa_sum4  = fa_a4 ^ fa_b4 ^ fa_cin4;
   assign fa_cout4 = (fa_a4 & fa_b4) | (fa_a4 & fa_cin4) | (fa_b4 & fa_cin4);

`ifndef SERIAL_ADDER_OVF_EN
   assign ovf8 = 1'b0;
   assign ovf4 = 1'b0;
`endif

   serial_adder_ctrl #(.WIDTH(8)) u8 (
      .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
      .fa_a(fa_a8), .fa_b(fa_b8), .fa_cin(fa_cin8), .fa_sum(fa_sum8), .fa_cout(fa_cout8),
      .busy(busy8), .done(done8), .sum(sum8),
`ifdef SERIAL_ADDER_OVF_EN
      .overflow(ovf8),
`endif
      .cout(cout8)
   );

   serial_adder_ctrl #(.WIDTH(4)) u4 (
      .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
      .fa_a(fa_a4), .fa_b(fa_b4), .fa_cin(fa_cin4), .fa_sum(fa_sum4), .fa_cout(fa_cout4),
      .busy(busy4), .done(done4), .sum(sum4),
`ifdef SERIAL_ADDER_OVF_EN
      .overflow(ovf4),
`endif
      .cout(cout4)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One full addition on the 8-bit instance with bounded wait for done.
   task automatic add8(input logic [7:0] va, input logic [7:0] vb, input logic vc,
                       input logic [7:0] es, input logic ec, input logic eo, input string tag);
      int unsigned busy_n;
      int unsigned cyc;
      @(negedge clk);
      a8 = va; b8 = vb; cin8 = vc; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0; a8 = ~va; b8 = ~vb; cin8 = ~vc;
      busy_n = 0; cyc = 0;
      while (!done8 && cyc < 40) begin
         if (busy8) busy_n++;
         cyc++;
         @(negedge clk);
      end
      check({tag, "_busy_cycles"}, 64'(busy_n), 64'd8);
      check({tag, "_done"}, 64'(done8), 64'd1);
      check({tag, "_sum"}, 64'(sum8), 64'(es));
      check({tag, "_cout"}, 64'(cout8), 64'(ec));
`ifdef SERIAL_ADDER_OVF_EN
      check({tag, "_overflow"}, 64'(ovf8), 64'(eo));
`endif
      @(negedge clk);
      check({tag, "_done_drop"}, 64'(done8), 64'd0);
      check({tag, "_sum_hold"}, 64'(sum8), 64'(es));
   endtask

   initial begin
      int unsigned done_n;
      int unsigned cyc;
      logic [7:0]  cap_sum;
      logic        prev;
      logic [4:0]  exp5;

      rst = 1'b1;
      start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
      start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
      repeat (2) @(negedge clk);
      check("reset_busy", 64'(busy8), 64'd0);
      check("reset_done", 64'(done8), 64'd0);
      check("reset_sum", 64'(sum8), 64'd0);
      check("reset_cout", 64'(cout8), 64'd0);
      check("reset_fa", 64'({fa_a8, fa_b8, fa_cin8}), 64'd0);
      check("reset_ovf", 64'(ovf8), 64'd0);
      rst = 1'b0;

      // Directed 8-bit vectors: a, b, cin, sum, cout, overflow
      add8(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1, "v5a_3c");
      add8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "vff_01");
      add8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, "vff_ff_c");
      add8(8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0, "v00_00_c");
      add8(8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0, 1'b0, "vaa_55");
      add8(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, "v80_80");
      add8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, "v7f_01");
      add8(8'h80, 8'hFF, 1'b0, 8'h7F, 1'b1, 1'b1, "v80_ff");
      add8(8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0, "v05_03");

      // Start during RUN is ignored; exactly one done pulse.
      @(negedge clk);
      a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      @(negedge clk);
      a8 = 8'hAA; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      done_n = 0; cap_sum = '0;
      for (int i = 0; i < 25; i++) begin
         if (done8) begin
            done_n++;
            cap_sum = sum8;
         end
         @(negedge clk);
      end
      check("restart_done_pulses", 64'(done_n), 64'd1);
      check("restart_sum", 64'(cap_sum), 64'h30);
      check("restart_cout", 64'(cout8), 64'd0);
      check("restart_idle", 64'(busy8), 64'd0);

      // Reset on the 4th RUN cycle discards the operation.
      a8 = 8'h5A; b8 = 8'h3C; cin8 = 1'b0; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      repeat (3) @(negedge clk);
      check("pre_rst_busy", 64'(busy8), 64'd1);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_busy", 64'(busy8), 64'd0);
      check("midrst_done", 64'(done8), 64'd0);
      check("midrst_sum", 64'(sum8), 64'd0);
      check("midrst_cout", 64'(cout8), 64'd0);
      check("midrst_fa", 64'({fa_a8, fa_b8, fa_cin8}), 64'd0);
      rst = 1'b0;
      done_n = 0;
      for (int i = 0; i < 12; i++) begin
         if (done8 || busy8) done_n++;
         @(negedge clk);
      end
      check("midrst_stays_idle", 64'(done_n), 64'd0);
      add8(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, "post_rst");

      // Exhaustive 4-bit sweep with carry-chain check on every RUN cycle.
      for (int ai = 0; ai < 16; ai++) begin
         for (int bi = 0; bi < 16; bi++) begin
            for (int ci = 0; ci < 2; ci++) begin
               @(negedge clk);
               a4 = 4'(ai); b4 = 4'(bi); cin4 = 1'(ci); start4 = 1'b1;
               @(negedge clk);
               start4 = 1'b0;
               prev = 1'(ci);
               cyc = 0;
               while (busy4 && cyc < 20) begin
                  check("w4_fa_cin", 64'(fa_cin4), 64'(prev));
                  prev = fa_cout4;
                  cyc++;
                  @(negedge clk);
               end
               exp5 = 5'(ai) + 5'(bi) + 5'(ci);
               check("w4_run_cycles", 64'(cyc), 64'd4);
               check("w4_done", 64'(done4), 64'd1);
               check("w4_result", 64'({cout4, sum4}), 64'(exp5));
            end
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Bit-serial adder controller that sits directly upstream of the single-bit full_adder cell and consumes the cell's outputs.
- Latches two WIDTH-bit operands and presents them to the cell one bit per clock, LSB first, keeping the carry in a flip-flop.
- Assembles the returned sum bits into a WIDTH-bit result and flags completion with a one-cycle done pulse.
- Gives an area-minimal adder made of one full_adder instance and this block.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new addition; sampled only in IDLE.
- a  input  WIDTH  operand A; sampled on the accepting start edge.
- b  input  WIDTH  operand B; sampled on the accepting start edge.
- cin  input  1  initial carry-in; sampled on the accepting start edge.
- fa_a  output  1  bit to full_adder input a.
- fa_b  output  1  bit to full_adder input b.
- fa_cin  output  1  carry to full_adder input cin.
- fa_sum  input  1  sum bit from full_adder.
- fa_cout  input  1  carry-out from full_adder.
- busy  output  1  high while the serial add is in progress.
- done  output  1  one-cycle pulse: result is valid.
- sum  output  WIDTH  result; held until the next accepted start.
- cout  output  1  final carry-out; held with sum.

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE; busy=0; done=0; sum=0; cout=0; fa_a=fa_b=fa_cin=0; internal shift registers, carry flop and bit counter cleared. Reset applies in any state, including mid-RUN; the partial result is discarded.
- FSM states: IDLE, RUN, DONE.
- IDLE: start=1 at an edge loads a_sh<=a, b_sh<=b, carry_q<=cin, cnt<=0 and moves to RUN. start=0 stays in IDLE.
- RUN: fa_a=a_sh[0], fa_b=b_sh[0] and fa_cin=carry_q, all combinational from registers. At each edge:
  - a_sh and b_sh shift right by 1.
  - sum_sh shifts right with fa_sum inserted at the MSB.
  - carry_q<=fa_cout; cnt<=cnt+1.
  - When cnt==WIDTH-1, sum<=updated sum_sh, cout<=fa_cout, and the state moves to DONE.
- DONE: done=1 for exactly one cycle, then unconditionally to IDLE.
- busy=1 only in RUN. fa_* outputs are 0 outside RUN.
- Latency: start accepted at edge k; RUN occupies edges k+1..k+WIDTH; done is high during the cycle after edge k+WIDTH. sum and cout are stable from that cycle on.
- start while in RUN or DONE is ignored, with no queuing; a and b may change freely after acceptance.
- cnt width is clog2(WIDTH); it never wraps within an operation.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1), unsigned.
- sum and cout change only at the final RUN edge or on reset.

Optional Feature:
- Macro: SERIAL_ADDER_OVF_EN.
- Defined: adds output port overflow (1 bit), reset 0. Captured at the final RUN edge as fa_cin XOR fa_cout of the MSB step, which is two's-complement signed overflow. Held alongside sum.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- WIDTH=8; a=8'h5A, b=8'h3C, cin=0, pulse start -> busy high 8 cycles, done pulses once; sum=8'h96, cout=0.
- a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1. a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
- Exhaustive WIDTH=4 sweep of all a, b, cin (512 cases) -> {cout,sum} == a+b+cin every time; fa_cin on each RUN cycle equals the previous fa_cout.
- Start a=8'h10, b=8'h20; re-pulse start with a=8'hAA during RUN -> ignored; result 8'h30, exactly one done pulse.
- Assert rst on the 4th RUN cycle -> next cycle busy=0, done=0, sum=0, cout=0, FSM in IDLE; a fresh start of 8'h01+8'h01 gives 8'h02.
- SERIAL_ADDER_OVF_EN defined: 8'h7F+8'h01 -> sum=8'h80, overflow=1; 8'h80+8'hFF -> sum=8'h7F, cout=1, overflow=1; 8'h05+8'h03 -> overflow=0.
